// File: rtl/mulu_x4y4_seq_pkg.sv
// Shared types and widths for the sequential 4x4 multiplier.
// Feature macro handled by the top: MULU_SEQ_EARLY_OUT_EN.
package mulu_x4y4_seq_pkg;

  localparam int DIG_W  = 2;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Weight a digit-pair product by 2*(i+j), with i=k[0], j=k[1].
  function automatic logic [PROD_W-1:0] place(
    input logic [2*DIG_W-1:0] pp,
    input logic [1:0]         k
  );
    logic [PROD_W-1:0] r;
    unique case (k)
      2'd0:    r = {4'b0, pp};
      2'd3:    r = {pp, 4'b0};
      default: r = {2'b0, pp, 2'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mulu_x2y2.sv
// Shared combinational 2x2 unsigned multiplier core.
// Feature macro MULU_SEQ_EARLY_OUT_EN does not affect this file.
import mulu_x4y4_seq_pkg::*;

module mulu_x2y2 (
  input  logic [DIG_W-1:0]   a,
  input  logic [DIG_W-1:0]   b,
  output logic [2*DIG_W-1:0] p
);

  assign p = {2'b0, a} * {2'b0, b};

endmodule

// File: rtl/mulu_x4y4_seq.sv
// Sequential 4x4 multiplier: four digit-pair steps on one 2x2 core.
// Define MULU_SEQ_EARLY_OUT_EN to finish zero-operand jobs at once.
import mulu_x4y4_seq_pkg::*;

module mulu_x4y4_seq #(
  parameter bit HOLD_RESULT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] p
);

  state_t              state;
  logic [1:0]          k;
  logic [PROD_W-1:0]   acc;
  logic [OP_W-1:0]     xr;
  logic [OP_W-1:0]     yr;
  logic [DIG_W-1:0]    cx;
  logic [DIG_W-1:0]    cy;
  logic [2*DIG_W-1:0]  cp;
  logic [PROD_W-1:0]   partial;
  logic                accept;

  always_comb begin
    cx = '0;
    cy = '0;
    if (state == RUN) begin
      cx = k[0] ? xr[3:2] : xr[1:0];
      cy = k[1] ? yr[3:2] : yr[1:0];
    end
  end

  mulu_x2y2 u_core (
    .a (cx),
    .b (cy),
    .p (cp)
  );

  assign partial = place(cp, k);
  assign accept  = start && (state != RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k     <= '0;
      acc   <= '0;
      xr    <= '0;
      yr    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
    end else if (accept) begin
      xr  <= x;
      yr  <= y;
      acc <= '0;
      k   <= '0;
      if (!HOLD_RESULT) p <= '0;
`ifdef MULU_SEQ_EARLY_OUT_EN
      if (x == '0 || y == '0) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        p     <= '0;
      end else begin
        state <= RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
`else
      state <= RUN;
      busy  <= 1'b1;
      done  <= 1'b0;
`endif
    end else begin
      unique case (state)
        RUN: begin
          acc <= acc + partial;
          k   <= k + 2'd1;
          if (k == 2'd3) begin
            p     <= acc + partial;
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mulu_x4y4_seq.sv
// Directed bench for mulu_x4y4_seq with hand-computed products.
// Follows MULU_SEQ_EARLY_OUT_EN when it is defined for the build.
module tb_mulu_x4y4_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] x = '0;
  logic [3:0] y = '0;
  logic       busy;
  logic       done;
  logic [7:0] p;

  int total = 0;
  int bad = 0;
  int dones = 0;
  int d0;

  mulu_x4y4_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) dones++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_full(input string tag, input logic [3:0] a,
                          input logic [3:0] b, input int exp,
                          input bit scramble);
    x = a;
    y = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (scramble) begin
      x = ~a;
      y = ~b;
    end
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, int'(busy), 1);
      chk({tag, "_nodone"}, int'(done), 0);
      tick();
    end
    chk({tag, "_idle"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 1);
    chk({tag, "_p"}, int'(p), exp);
    tick();
    chk({tag, "_pulse"}, int'(done), 0);
    chk({tag, "_hold"}, int'(p), exp);
  endtask

  initial begin
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_p", int'(p), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    run_full("m15x15", 4'd15, 4'd15, 225, 1'b0);
    run_full("m3x2", 4'd3, 4'd2, 6, 1'b1);

`ifdef MULU_SEQ_EARLY_OUT_EN
    x = 4'd0;
    y = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("early_busy", int'(busy), 0);
    chk("early_done", int'(done), 1);
    chk("early_p", int'(p), 0);
    tick();
    chk("early_pulse", int'(done), 0);
    chk("early_busy2", int'(busy), 0);
`else
    run_full("m0x9", 4'd0, 4'd9, 0, 1'b0);
`endif

    // start held during RUN must be ignored
    d0 = dones;
    x = 4'd7;
    y = 4'd9;
    start = 1'b1;
    tick();
    x = 4'd1;
    y = 4'd1;
    for (int i = 0; i < 4; i++) begin
      chk("ign_busy", int'(busy), 1);
      if (i == 2) start = 1'b0;
      tick();
    end
    chk("ign_done", int'(done), 1);
    chk("ign_p", int'(p), 63);

    // back-to-back accept in the DONE cycle
    x = 4'd10;
    y = 4'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_done", int'(done), 0);
    chk("ign_ndone", dones - d0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_hold", int'(p), 63);
      tick();
    end
    chk("b2b_hold4", int'(p), 63);
    tick();
    chk("b2b_done2", int'(done), 1);
    chk("b2b_p", int'(p), 120);
    tick();

    // asynchronous reset at step k=2
    d0 = dones;
    x = 4'd5;
    y = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("abort_pre", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_p", int'(p), 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("abort_nodone", dones - d0, 0);
    chk("abort_p2", int'(p), 0);
    run_full("m13x11", 4'd13, 4'd11, 143, 1'b0);

    // continuous start: done every 5 cycles
    x = 4'd2;
    y = 4'd3;
    start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("cont_done1", int'(done), 1);
    chk("cont_p1", int'(p), 6);
    tick();
    chk("cont_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("cont_done2", int'(done), 1);
    start = 1'b0;
    tick();
    chk("cont_end", int'(done), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
